// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module  : pipeline_ctrl_pkg
// Brief   : State encoding, debug command codes and hazard helper for the
//           pipeline controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HALTED = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CMD_NONE = 2'b00,
      CMD_RUN  = 2'b01,
      CMD_STEP = 2'b10,
      CMD_HALT = 2'b11
   } dbg_cmd_t;

   localparam int C_DRAIN_CYCLES_DEF = 4;

   // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
   function automatic logic loadUseHazard(
      input logic       memRead,
      input logic [4:0] exRegAddr,
      input logic [4:0] idRs,
      input logic [4:0] idRt,
      input logic       usesRt
   );
      return memRead && (exRegAddr != 5'd0) &&
             ((exRegAddr == idRs) || (usesRt && (exRegAddr == idRt)));
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
// ============================================================================
// Module  : pipeline_ctrl_if
// Brief   : Debug handshake, ID/EX hazard inputs and control/counter outputs
//           of the pipeline controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_ctrl_if #(
   parameter int CNT_W = 16
);

   logic [1:0]       dbg_cmd;
   logic             dbg_cmd_valid;
   logic             dbg_cmd_ready;

   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             id_halt;
   logic             ex_memRead;
   logic [4:0]       ex_regAddr;
   logic             ex_isJumped;

   logic             pipe_en;
   logic             pc_write;
   logic             if_id_write;
   logic             id_ex_bubble;
   logic             flush;
   logic             halted;
   logic             step_done;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] stall_count;

   // Pipeline / debugger side
   modport master (
      output dbg_cmd, dbg_cmd_valid,
      output id_rs, id_rt, id_uses_rt, id_halt,
      output ex_memRead, ex_regAddr, ex_isJumped,
      input  dbg_cmd_ready,
      input  pipe_en, pc_write, if_id_write, id_ex_bubble, flush,
      input  halted, step_done, cycle_count, stall_count
   );

   // Controller side
   modport slave (
      input  dbg_cmd, dbg_cmd_valid,
      input  id_rs, id_rt, id_uses_rt, id_halt,
      input  ex_memRead, ex_regAddr, ex_isJumped,
      output dbg_cmd_ready,
      output pipe_en, pc_write, if_id_write, id_ex_bubble, flush,
      output halted, step_done, cycle_count, stall_count
   );

endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : WIDTH-bit incrementer that sticks at all-ones instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int WIDTH = 16
) (
   input  wire logic             clock,
   input  wire logic             reset,
   input  wire logic             inc,
   output logic [WIDTH-1:0]      count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (inc && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module  : pipeline_ctrl
// Brief   : Run/step/halt debug controller with load-use stall, branch flush
//           and saturating performance counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int DRAIN_CYCLES = C_DRAIN_CYCLES_DEF
) (
   input  wire logic       clock,
   input  wire logic       reset,
   pipeline_ctrl_if.slave  bus
);

   localparam int                C_DRAIN_W    = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [C_DRAIN_W-1:0] C_DRAIN_LAST = C_DRAIN_W'(DRAIN_CYCLES - 1);

   state_t               r_state;
   state_t               w_stateNext;
   logic [C_DRAIN_W-1:0] r_drainCnt;
   logic [C_DRAIN_W-1:0] w_drainCntNext;
   logic                 r_stepDone;
   logic                 w_stepDoneNext;

   dbg_cmd_t             w_cmd;
   logic                 w_cmdReady;
   logic                 w_cmdAccept;
   logic                 w_enabled;
   logic                 w_hazard;
   logic                 w_pcWrite;
   logic                 w_ifIdWrite;
   logic                 w_bubble;
   logic                 w_flush;
   logic                 w_stallInc;

   assign w_cmd       = dbg_cmd_t'(bus.dbg_cmd);
   assign w_cmdReady  = (r_state == ST_HALTED) || (r_state == ST_RUN);
   assign w_cmdAccept = bus.dbg_cmd_valid && w_cmdReady;
   assign w_enabled   = (r_state != ST_HALTED);
   assign w_hazard    = loadUseHazard(bus.ex_memRead, bus.ex_regAddr,
                                      bus.id_rs, bus.id_rt, bus.id_uses_rt);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_HALTED;
         r_drainCnt <= '0;
         r_stepDone <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_drainCnt <= w_drainCntNext;
         r_stepDone <= w_stepDoneNext;
      end
   end

   always_comb begin
      w_stateNext    = r_state;
      w_drainCntNext = r_drainCnt;
      w_stepDoneNext = 1'b0;
      w_pcWrite      = 1'b0;
      w_ifIdWrite    = 1'b0;
      w_bubble       = 1'b0;
      w_flush        = 1'b0;
      w_stallInc     = 1'b0;

      case (r_state)
         ST_HALTED: begin
            // halt and none are accepted here but have no effect
            if (w_cmdAccept) begin
               if (w_cmd == CMD_RUN) begin
                  w_stateNext = ST_RUN;
               end else if (w_cmd == CMD_STEP) begin
                  w_stateNext = ST_STEP;
               end
            end
         end

         ST_RUN, ST_STEP: begin
            // A taken branch squashes the younger instructions, so any hazard
            // they raise is moot and the redirect must proceed.
            if (bus.ex_isJumped) begin
               w_pcWrite   = 1'b1;
               w_ifIdWrite = 1'b1;
               w_flush     = 1'b1;
            end else if (w_hazard) begin
               w_bubble    = 1'b1;
               w_stallInc  = 1'b1;
            end else begin
               w_pcWrite   = 1'b1;
               w_ifIdWrite = 1'b1;
            end

            if (r_state == ST_STEP) begin
               w_stateNext    = ST_HALTED;
               w_stepDoneNext = 1'b1;
            end else if ((w_cmdAccept && (w_cmd == CMD_HALT)) ||
                         (bus.id_halt && !bus.ex_isJumped)) begin
               w_stateNext    = ST_DRAIN;
               w_drainCntNext = '0;
            end
         end

         ST_DRAIN: begin
            w_bubble = 1'b1;
            if (r_drainCnt == C_DRAIN_LAST) begin
               w_stateNext = ST_HALTED;
            end else begin
               w_drainCntNext = r_drainCnt + 1'b1;
            end
         end

         default: begin
            w_stateNext = ST_HALTED;
         end
      endcase
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_cycleCnt (
      .clock (clock),
      .reset (reset),
      .inc   (w_enabled),
      .count (bus.cycle_count)
   );

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stallCnt (
      .clock (clock),
      .reset (reset),
      .inc   (w_stallInc),
      .count (bus.stall_count)
   );

   assign bus.dbg_cmd_ready = w_cmdReady;
   assign bus.pipe_en       = w_enabled;
   assign bus.pc_write      = w_pcWrite;
   assign bus.if_id_write   = w_ifIdWrite;
   assign bus.id_ex_bubble  = w_bubble;
   assign bus.flush         = w_flush;
   assign bus.halted        = (r_state == ST_HALTED);
   assign bus.step_done     = r_stepDone;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_ctrl
// Brief   : Scoreboard bench for pipeline_ctrl, plus a 4-bit counter instance.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int H = 0, R = 1, S = 2, D = 3;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   pipeline_ctrl_if #(.CNT_W(16)) bus ();
   pipeline_ctrl_if #(.CNT_W(4))  bus4 ();

   pipeline_ctrl #(.CNT_W(16), .DRAIN_CYCLES(4)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   pipeline_ctrl #(.CNT_W(4), .DRAIN_CYCLES(4)) u_dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4)
   );

   typedef struct {
      logic pipeEn;
      logic pcW;
      logic ifidW;
      logic bubble;
      logic flush;
      logic halted;
      logic stepDone;
      logic ready;
      int   cyc;
      int   stall;
   } exp_t;

   exp_t sbQ[$];

   int mState, mDrain, mCyc, mStall;
   bit mStepDone;
   int nChecks, nErrors;

   logic        oHalted, oStepDone, oPcW, oBubble, oFlush, oPipeEn;
   logic [15:0] oCyc, oStall;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t modelOut();
      exp_t e;
      logic haz;
      haz = bus.ex_memRead && (bus.ex_regAddr != 5'd0) &&
            ((bus.ex_regAddr == bus.id_rs) || (bus.id_uses_rt && (bus.ex_regAddr == bus.id_rt)));
      e.pipeEn = (mState != H);
      e.ready  = (mState == H) || (mState == R);
      e.halted = (mState == H);
      e.stepDone = mStepDone;
      e.cyc = mCyc;
      e.stall = mStall;
      e.pcW = 0; e.ifidW = 0; e.bubble = 0; e.flush = 0;
      if (mState == R || mState == S) begin
         if (bus.ex_isJumped) begin
            e.pcW = 1; e.ifidW = 1; e.flush = 1;
         end else if (haz) begin
            e.bubble = 1;
         end else begin
            e.pcW = 1; e.ifidW = 1;
         end
      end else if (mState == D) begin
         e.bubble = 1;
      end
      return e;
   endfunction

   task automatic modelReset();
      mState = H; mDrain = 0; mCyc = 0; mStall = 0; mStepDone = 0;
   endtask

   task automatic modelAdvance(input exp_t e);
      bit accept;
      accept = bus.dbg_cmd_valid && e.ready;
      if (e.pipeEn && mCyc < 65535) mCyc++;
      if ((mState == R || mState == S) && e.bubble && mStall < 65535) mStall++;
      mStepDone = 0;
      case (mState)
         H: if (accept) begin
               if (bus.dbg_cmd == CMD_RUN) mState = R;
               else if (bus.dbg_cmd == CMD_STEP) mState = S;
            end
         R: if ((accept && bus.dbg_cmd == CMD_HALT) || (bus.id_halt && !bus.ex_isJumped)) begin
               mState = D; mDrain = 0;
            end
         S: begin mState = H; mStepDone = 1; end
         default: if (mDrain == 3) mState = H; else mDrain++;
      endcase
   endtask

   // Called just after a falling edge with inputs already driven for this cycle.
   task automatic tick();
      exp_t e, p;
      if (!reset) modelReset();
      e = modelOut();
      sbQ.push_back(e);
      #1;
      p = sbQ.pop_front();
      oHalted = bus.halted; oStepDone = bus.step_done; oPcW = bus.pc_write;
      oBubble = bus.id_ex_bubble; oFlush = bus.flush; oPipeEn = bus.pipe_en;
      oCyc = bus.cycle_count; oStall = bus.stall_count;
      chk("pipe_en", bus.pipe_en, p.pipeEn);
      chk("pc_write", bus.pc_write, p.pcW);
      chk("if_id_write", bus.if_id_write, p.ifidW);
      chk("id_ex_bubble", bus.id_ex_bubble, p.bubble);
      chk("flush", bus.flush, p.flush);
      chk("halted", bus.halted, p.halted);
      chk("step_done", bus.step_done, p.stepDone);
      chk("dbg_cmd_ready", bus.dbg_cmd_ready, p.ready);
      chk("cycle_count", bus.cycle_count, p.cyc);
      chk("stall_count", bus.stall_count, p.stall);
      if (reset) modelAdvance(p);
      @(negedge clock);
   endtask

   task automatic idle();
      bus.dbg_cmd = CMD_NONE; bus.dbg_cmd_valid = 0;
      bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0; bus.id_halt = 0;
      bus.ex_memRead = 0; bus.ex_regAddr = 0; bus.ex_isJumped = 0;
   endtask

   task automatic cmd(input logic [1:0] c);
      bus.dbg_cmd = c; bus.dbg_cmd_valid = 1;
   endtask

   initial begin
      nChecks = 0; nErrors = 0;
      reset = 0;
      idle();
      bus4.dbg_cmd = CMD_NONE; bus4.dbg_cmd_valid = 0;
      bus4.id_rs = 0; bus4.id_rt = 0; bus4.id_uses_rt = 0; bus4.id_halt = 0;
      bus4.ex_memRead = 0; bus4.ex_regAddr = 0; bus4.ex_isJumped = 0;
      modelReset();
      @(negedge clock);
      tick(); tick();
      chk("rst_halted", oHalted, 1);
      chk("rst_pipe_en", oPipeEn, 0);
      chk("rst_cycle_count", oCyc, 0);

      // Release; small instance runs with a permanent load-use hazard
      reset = 1;
      bus4.dbg_cmd = CMD_RUN; bus4.dbg_cmd_valid = 1;
      bus4.ex_memRead = 1; bus4.ex_regAddr = 5'd1; bus4.id_rs = 5'd1;
      tick();
      bus4.dbg_cmd_valid = 0;

      cmd(CMD_RUN); tick(); idle();
      repeat (11) tick();
      chk("run_cycle_count_10", oCyc, 10);
      chk("run_halted", oHalted, 0);

      // Load-use on rs
      bus.ex_memRead = 1; bus.ex_regAddr = 5'd5; bus.id_rs = 5'd5; tick();
      chk("haz_pc_write", oPcW, 0);
      chk("haz_bubble", oBubble, 1);
      idle(); tick();
      chk("haz_stall_count", oStall, 1);
      bus.ex_memRead = 1; bus.ex_regAddr = 5'd0; bus.id_rs = 5'd0; tick();
      chk("r0_no_bubble", oBubble, 0);
      idle(); tick();
      chk("r0_stall_count", oStall, 1);

      // Load-use on rt, with and without id_uses_rt
      bus.ex_memRead = 1; bus.ex_regAddr = 5'd7; bus.id_rt = 5'd7; bus.id_rs = 5'd3;
      bus.id_uses_rt = 1; tick();
      bus.id_uses_rt = 0; tick();
      idle(); tick();
      chk("rt_stall_count", oStall, 2);

      // Jump overrides hazard
      bus.ex_memRead = 1; bus.ex_regAddr = 5'd5; bus.id_rs = 5'd5; bus.ex_isJumped = 1; tick();
      chk("jmp_flush", oFlush, 1);
      chk("jmp_pc_write", oPcW, 1);
      chk("jmp_bubble", oBubble, 0);
      idle(); tick();
      chk("jmp_stall_count", oStall, 2);
      chk("sat_cycle_count", bus4.cycle_count, 15);

      // Squashed HALT, then real HALT and drain
      bus.id_halt = 1; bus.ex_isJumped = 1; tick();
      idle(); tick();
      chk("squash_halted", oHalted, 0);
      bus.id_halt = 1; tick(); idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("drain_pc_write", oPcW, 0);
         chk("drain_halted", oHalted, 0);
      end
      tick();
      chk("drain_done_halted", oHalted, 1);

      // Single step
      cmd(CMD_STEP); tick(); idle();
      tick();
      chk("step_pipe_en", oPipeEn, 1);
      tick();
      chk("step_done_pulse", oStepDone, 1);
      chk("step_halted", oHalted, 1);
      tick();
      chk("step_done_once", oStepDone, 0);
      chk("step_pipe_en_off", oPipeEn, 0);

      // Halt command together with id_halt
      cmd(CMD_RUN); tick(); idle();
      tick();
      cmd(CMD_HALT); bus.id_halt = 1; tick(); idle();
      repeat (4) tick();
      chk("dual_halt_draining", oHalted, 0);
      tick();
      chk("dual_halt_halted", oHalted, 1);
      chk("sat_cycle_hold", bus4.cycle_count, 15);
      chk("sat_stall_hold", bus4.stall_count, 15);

      // Reset during the second drain cycle
      cmd(CMD_STEP); tick(); idle();
      tick(); tick();
      cmd(CMD_RUN); tick(); idle();
      bus.id_halt = 1; tick(); idle();
      tick();
      reset = 0;
      tick();
      chk("rst_drain_halted", oHalted, 1);
      chk("rst_drain_cycle", oCyc, 0);
      chk("rst_drain_stall", oStall, 0);
      reset = 1;
      tick(); tick();
      chk("rst_drain_no_step_done", oStepDone, 0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule

`default_nettype wire
